// File: rtl/scanout_pkg.sv
// Shared timing constants, colour types and the fixed gameboard palette for the frame scanout engine.
package scanout_pkg;

    localparam int unsigned H_TOTAL      = 800;
    localparam int unsigned H_SYNC_START = 656;
    localparam int unsigned H_SYNC_END   = 752;
    localparam int unsigned V_TOTAL      = 525;
    localparam int unsigned V_SYNC_START = 490;
    localparam int unsigned V_SYNC_END   = 492;
    localparam int unsigned FRAME_PIXELS = 307200;
    localparam int unsigned ADDR_W       = 20;

    typedef logic [2:0] color_idx_t;

    typedef struct packed {
        logic [7:0] r;
        logic [7:0] g;
        logic [7:0] b;
    } rgb_t;

    // Index order: black, wall blue, pellet, pac yellow, Blinky, Pinky, Inky, Clyde.
    localparam rgb_t PALETTE [8] = '{
        rgb_t'(24'h000000),
        rgb_t'(24'h2121DE),
        rgb_t'(24'hFFB8AE),
        rgb_t'(24'hFFFF00),
        rgb_t'(24'hFF0000),
        rgb_t'(24'hFFB8FF),
        rgb_t'(24'h00FFFF),
        rgb_t'(24'hFFB852)
    };

endpackage

// File: rtl/frame_scanout_vga_timing.sv
// vga_timing: pixel-clock divider, hc/vc raster counters, sync/visibility decode and frame_start.
module vga_timing
    import scanout_pkg::*;
#(
    parameter int unsigned CLK_DIV = 2,
    parameter int unsigned H_VIS   = 640,
    parameter int unsigned V_VIS   = 480,
    parameter int unsigned H_TOT   = H_TOTAL,
    parameter int unsigned H_SS    = H_SYNC_START,
    parameter int unsigned H_SE    = H_SYNC_END,
    parameter int unsigned V_TOT   = V_TOTAL,
    parameter int unsigned V_SS    = V_SYNC_START,
    parameter int unsigned V_SE    = V_SYNC_END
) (
    input  logic i_clk,
    input  logic i_rst_n,
    output logic o_pix_en_c,
    output logic o_wrap_c,
    output logic o_vis_c,
    output logic o_vis_nxt_c,
    output logic o_hs_n_c,
    output logic o_vs_n_c,
    output logic o_vblank_c,
    output logic o_vga_clk,
    output logic o_frame_start
);

    localparam int unsigned DIV_W = $clog2(CLK_DIV);
    localparam int unsigned HC_W  = $clog2(H_TOT);
    localparam int unsigned VC_W  = $clog2(V_TOT);

    logic [DIV_W-1:0] r_div, w_div_nxt;
    logic [HC_W-1:0]  r_hc, w_hc_nxt;
    logic [VC_W-1:0]  r_vc, w_vc_nxt;
    logic             r_vga_clk, r_frame_start;
    logic             w_pix_en, w_h_last, w_v_last, w_wrap;

    // Next-position logic; the counters only move on the last Clk of a pixel.
    always_comb begin
        w_pix_en  = (r_div == DIV_W'(CLK_DIV - 1));
        w_h_last  = (r_hc == HC_W'(H_TOT - 1));
        w_v_last  = (r_vc == VC_W'(V_TOT - 1));
        w_wrap    = w_pix_en && w_h_last && w_v_last;
        w_div_nxt = w_pix_en ? '0 : r_div + 1'b1;
        w_hc_nxt  = r_hc;
        w_vc_nxt  = r_vc;
        if (w_pix_en) begin
            if (w_h_last) begin
                w_hc_nxt = '0;
                w_vc_nxt = w_v_last ? '0 : r_vc + 1'b1;
            end else begin
                w_hc_nxt = r_hc + 1'b1;
            end
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_div         <= '0;
            r_hc          <= '0;
            r_vc          <= '0;
            r_vga_clk     <= 1'b1;
            r_frame_start <= 1'b0;
        end else begin
            r_div         <= w_div_nxt;
            r_hc          <= w_hc_nxt;
            r_vc          <= w_vc_nxt;
            r_vga_clk     <= (w_div_nxt < DIV_W'(CLK_DIV / 2));
            r_frame_start <= w_wrap;
        end
    end

    assign o_pix_en_c    = w_pix_en;
    assign o_wrap_c      = w_wrap;
    assign o_vis_c       = (r_hc < HC_W'(H_VIS)) && (r_vc < VC_W'(V_VIS));
    assign o_vis_nxt_c   = (w_hc_nxt < HC_W'(H_VIS)) && (w_vc_nxt < VC_W'(V_VIS));
    assign o_hs_n_c      = !((r_hc >= HC_W'(H_SS)) && (r_hc < HC_W'(H_SE)));
    assign o_vs_n_c      = !((r_vc >= VC_W'(V_SS)) && (r_vc < VC_W'(V_SE)));
    assign o_vblank_c    = (r_vc >= VC_W'(V_VIS));
    assign o_vga_clk     = r_vga_clk;
    assign o_frame_start = r_frame_start;

endmodule

// File: rtl/frame_scanout.sv
// Frame buffer read engine: raster address generation, read-latency alignment and palette output stage.
// Optional double buffering (swap_req/front_sel) is enabled with the SCANOUT_DBUF_EN macro.
module frame_scanout
    import scanout_pkg::*;
#(
    parameter int unsigned CLK_DIV = 2,
    parameter int unsigned H_VIS   = 640,
    parameter int unsigned V_VIS   = 480,
    parameter int unsigned H_TOT   = H_TOTAL,
    parameter int unsigned H_SS    = H_SYNC_START,
    parameter int unsigned H_SE    = H_SYNC_END,
    parameter int unsigned V_TOT   = V_TOTAL,
    parameter int unsigned V_SS    = V_SYNC_START,
    parameter int unsigned V_SE    = V_SYNC_END
) (
    input  logic              Clk,
    input  logic              Reset_n,
    output logic [ADDR_W-1:0] read_address,
    input  color_idx_t        data_Out,
    output logic [7:0]        VGA_R,
    output logic [7:0]        VGA_G,
    output logic [7:0]        VGA_B,
    output logic              VGA_HS,
    output logic              VGA_VS,
    output logic              VGA_BLANK_N,
    output logic              VGA_CLK,
    output logic              frame_start,
    output logic              vblank
`ifdef SCANOUT_DBUF_EN
    ,
    input  logic              swap_req,
    output logic              front_sel
`endif
);

    logic              w_pix_en, w_wrap, w_vis, w_vis_nxt, w_hs_n, w_vs_n, w_vblank;
    logic [ADDR_W-1:0] r_addr_cnt, w_addr_nxt, w_rd_nxt, r_read_address;
    rgb_t              r_rgb;
    logic              r_hs_n, r_vs_n, r_blank_n, r_vblank;

    vga_timing #(
        .CLK_DIV (CLK_DIV),
        .H_VIS   (H_VIS),
        .V_VIS   (V_VIS),
        .H_TOT   (H_TOT),
        .H_SS    (H_SS),
        .H_SE    (H_SE),
        .V_TOT   (V_TOT),
        .V_SS    (V_SS),
        .V_SE    (V_SE)
    ) u_timing (
        .i_clk         (Clk),
        .i_rst_n       (Reset_n),
        .o_pix_en_c    (w_pix_en),
        .o_wrap_c      (w_wrap),
        .o_vis_c       (w_vis),
        .o_vis_nxt_c   (w_vis_nxt),
        .o_hs_n_c      (w_hs_n),
        .o_vs_n_c      (w_vs_n),
        .o_vblank_c    (w_vblank),
        .o_vga_clk     (VGA_CLK),
        .o_frame_start (frame_start)
    );

    // addr_cnt always holds the linear index of the current pixel, so no y*640 multiply is needed.
    always_comb begin
        w_addr_nxt = r_addr_cnt;
        if (w_pix_en) begin
            if (w_wrap) begin
                w_addr_nxt = '0;
            end else if (w_vis) begin
                w_addr_nxt = r_addr_cnt + 1'b1;
            end
        end
    end

`ifdef SCANOUT_DBUF_EN
    logic r_front_sel, r_swap_pend, w_swap_any, w_front_nxt;

    assign w_swap_any  = r_swap_pend | swap_req;
    assign w_front_nxt = (w_wrap && w_swap_any) ? !r_front_sel : r_front_sel;
    assign w_rd_nxt    = w_addr_nxt + (w_front_nxt ? ADDR_W'(FRAME_PIXELS) : '0);
    assign front_sel   = r_front_sel;

    // Swap requests stay pending until the next frame wrap, which flips the displayed half.
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            r_front_sel <= 1'b0;
            r_swap_pend <= 1'b0;
        end else begin
            r_front_sel <= w_front_nxt;
            r_swap_pend <= w_wrap ? 1'b0 : w_swap_any;
        end
    end
`else
    assign w_rd_nxt = w_addr_nxt;
`endif

    // Address is launched with the counters so the read data lands one Clk before the next pix_en.
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            r_addr_cnt     <= '0;
            r_read_address <= '0;
        end else begin
            r_addr_cnt <= w_addr_nxt;
            if (w_pix_en && w_vis_nxt) begin
                r_read_address <= w_rd_nxt;
            end
        end
    end

    // Output stage captures the pixel being left, so colour and sync share one pixel of delay.
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            r_rgb     <= '0;
            r_hs_n    <= 1'b1;
            r_vs_n    <= 1'b1;
            r_blank_n <= 1'b0;
            r_vblank  <= 1'b0;
        end else if (w_pix_en) begin
            r_rgb     <= w_vis ? PALETTE[data_Out] : '0;
            r_hs_n    <= w_hs_n;
            r_vs_n    <= w_vs_n;
            r_blank_n <= w_vis;
            r_vblank  <= w_vblank;
        end
    end

    assign read_address = r_read_address;
    assign VGA_R        = r_rgb.r;
    assign VGA_G        = r_rgb.g;
    assign VGA_B        = r_rgb.b;
    assign VGA_HS       = r_hs_n;
    assign VGA_VS       = r_vs_n;
    assign VGA_BLANK_N  = r_blank_n;
    assign vblank       = r_vblank;

endmodule
